// File: rtl/bp_update_ctrl_pkg.sv
// bp_update_ctrl_pkg
//   Shared definitions for the branch-predictor update controller:
//   default table geometry, FSM state encoding and the EX-update FIFO
//   entry layout.
//   Optional feature macro used by the design files: BP_UPD_COALESCE_EN.
package bp_update_ctrl_pkg;

  // Defaults kept in line with the predictor table (256 entries, 32-bit pc).
  localparam int BP_ADDR_W = 32;
  localparam int BP_IDX_W  = 8;
  localparam int BP_DEPTH  = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bp_state_e;

  // FIFO entry layout, MSB first: {pc, target, taken}.
  // Modules with a non-default ADDR_W pack the same field order into a
  // flat vector of entry_w(ADDR_W) bits.
  typedef struct packed {
    logic [BP_ADDR_W-1:0] pc;
    logic [BP_ADDR_W-1:0] target;
    logic                 taken;
  } bp_entry_t;

  function automatic int unsigned entry_w(input int unsigned addr_w);
    return 2 * addr_w + 1;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// bp_update_ctrl_if
//   Bundles the EX resolution inputs, the config write port and the
//   predictor-table write port of bp_update_ctrl.
//   master : driver side (EX stage / config / observer of table writes)
//   slave  : the update controller itself
//   Signals:
//     flush_req              request full table clear (pulse)
//     br_update/br/br_address/br_pc   EX branch resolution
//     cfg_we/cfg_pc/cfg_target/cfg_taken  config write (not stallable)
//     tbl_we/tbl_idx/tbl_tag/tbl_target/tbl_taken/tbl_valid  table write
//     busy                   clear sweep in progress
//     upd_drop               registered pulse, EX update lost to overflow
interface bp_update_ctrl_if
  import bp_update_ctrl_pkg::*;
#(
  parameter int ADDR_W = BP_ADDR_W,
  parameter int IDX_W  = BP_IDX_W
);

  logic              flush_req;
  logic              br_update;
  logic              br;
  logic [ADDR_W-1:0] br_address;
  logic [ADDR_W-1:0] br_pc;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_pc;
  logic [ADDR_W-1:0] cfg_target;
  logic              cfg_taken;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_idx;
  logic [ADDR_W-1:0] tbl_tag;
  logic [ADDR_W-1:0] tbl_target;
  logic              tbl_taken;
  logic              tbl_valid;
  logic              busy;
  logic              upd_drop;

  modport master (
    output flush_req, br_update, br, br_address, br_pc,
    output cfg_we, cfg_pc, cfg_target, cfg_taken,
    input  tbl_we, tbl_idx, tbl_tag, tbl_target, tbl_taken, tbl_valid,
    input  busy, upd_drop
  );

  modport slave (
    input  flush_req, br_update, br, br_address, br_pc,
    input  cfg_we, cfg_pc, cfg_target, cfg_taken,
    output tbl_we, tbl_idx, tbl_tag, tbl_target, tbl_taken, tbl_valid,
    output busy, upd_drop
  );

endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo
//   Small synchronous FIFO for buffered EX branch updates.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     flush             empty the FIFO (pointers/count back to 0)
//     push, push_data   enqueue; accepted when not full or popping
//     pop               dequeue head; ignored when empty
//     full, empty       status
//     head_data         combinational view of the oldest entry
//   With BP_UPD_COALESCE_EN defined, extra ports expose the youngest entry:
//     yng_q             youngest entry contents
//     yng_we, yng_data  overwrite the youngest entry in place
//     yng_popping       the youngest entry is the one being popped now
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
`ifdef BP_UPD_COALESCE_EN
  input  logic         yng_we,
  input  logic [W-1:0] yng_data,
  output logic [W-1:0] yng_q,
  output logic         yng_popping,
`endif
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [W-1:0]     mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

`ifdef BP_UPD_COALESCE_EN
  logic [PTR_W-1:0] yng_ptr;
  assign yng_ptr     = wr_ptr_reg - 1'b1;
  assign yng_q       = mem[yng_ptr];
  // When non-empty, youngest == head only with a single entry left.
  assign yng_popping = pop_ok && (yng_ptr == rd_ptr_reg);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (!push_ok && pop_ok) count_reg <= count_reg - 1'b1;
    end
  end

  // Entry storage needs no reset: count/pointers define what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (push_ok && wr_ptr_reg == PTR_W'(gi)) begin
        entry_reg <= push_data;
      end
`ifdef BP_UPD_COALESCE_EN
      else if (yng_we && yng_ptr == PTR_W'(gi)) begin
        entry_reg <= yng_data;
      end
`endif
    end
    assign mem[gi] = entry_reg;
  end

  assign head_data = mem[rd_ptr_reg];

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
//   Sequences every write into the branch-predictor table. After reset or a
//   flush request it sweeps the whole table clearing valid bits (busy=1),
//   then arbitrates the single write port between config writes (highest
//   priority) and EX branch resolutions buffered in a small FIFO.
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous active-low reset
//     bus   bp_update_ctrl_if.slave: EX update, config write, table write
//           port, busy and upd_drop
//   Optional feature: BP_UPD_COALESCE_EN -- an EX update whose pc matches
//   the youngest buffered entry overwrites that entry instead of allocating.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int DEPTH  = BP_DEPTH,
  parameter int IDX_W  = BP_IDX_W,
  parameter int ADDR_W = BP_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  bp_update_ctrl_if.slave  bus
);

  localparam int unsigned EW = entry_w(ADDR_W);
  localparam logic [IDX_W-1:0] CLR_LAST = '1;

  bp_state_e         state_reg;
  logic [IDX_W-1:0]  clr_idx_reg;
  logic              upd_drop_reg;

  logic              in_run;
  logic              take_upd;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop_next;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head_q;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] head_target;
  logic              head_taken;

  assign in_run     = (state_reg == ST_RUN);
  // Updates are only accepted while running; a flush discards the
  // same-cycle update.
  assign take_upd   = in_run && bus.br_update && !bus.flush_req;
  assign fifo_pop   = in_run && !bus.cfg_we && !fifo_empty;
  assign fifo_flush = in_run && bus.flush_req;
  assign push_data  = {bus.br_pc, bus.br_address, bus.br};

  assign head_pc     = head_q[EW-1 -: ADDR_W];
  assign head_target = head_q[ADDR_W -: ADDR_W];
  assign head_taken  = head_q[0];

`ifdef BP_UPD_COALESCE_EN
  logic [EW-1:0] yng_q;
  logic          yng_popping;
  logic          coalesce;

  // Merge into the youngest entry unless that entry leaves this cycle.
  assign coalesce  = take_upd && !fifo_empty && !yng_popping &&
                     (yng_q[EW-1 -: ADDR_W] == bus.br_pc);
  assign fifo_push = take_upd && !coalesce;
`else
  assign fifo_push = take_upd;
`endif

  // Lost update: nowhere to put it and nothing leaves this cycle.
  assign drop_next = fifo_push && fifo_full && !fifo_pop;

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (fifo_flush),
    .push        (fifo_push),
    .push_data   (push_data),
    .pop         (fifo_pop),
`ifdef BP_UPD_COALESCE_EN
    .yng_we      (coalesce),
    .yng_data    (push_data),
    .yng_q       (yng_q),
    .yng_popping (yng_popping),
`endif
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head_data   (head_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_CLEAR;
      clr_idx_reg  <= '0;
      upd_drop_reg <= 1'b0;
    end else begin
      upd_drop_reg <= drop_next;
      case (state_reg)
        ST_CLEAR: begin
          if (bus.flush_req) begin
            clr_idx_reg <= '0;
          end else begin
            clr_idx_reg <= clr_idx_reg + 1'b1;
            if (clr_idx_reg == CLR_LAST) state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.flush_req) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
          end
        end
        default: begin
          state_reg   <= ST_CLEAR;
          clr_idx_reg <= '0;
        end
      endcase
    end
  end

  // Write port: combinational from state, cfg inputs and FIFO head. During
  // a flush cycle in RUN the port still follows its normal arbitration; the
  // sweep that follows overwrites the whole table anyway.
  logic              tbl_we_c;
  logic [IDX_W-1:0]  tbl_idx_c;
  logic [ADDR_W-1:0] tbl_tag_c;
  logic [ADDR_W-1:0] tbl_target_c;
  logic              tbl_taken_c;
  logic              tbl_valid_c;

  always_comb begin
    tbl_we_c     = 1'b0;
    tbl_idx_c    = '0;
    tbl_tag_c    = '0;
    tbl_target_c = '0;
    tbl_taken_c  = 1'b0;
    tbl_valid_c  = 1'b0;
    if (!in_run) begin
      tbl_we_c  = 1'b1;
      tbl_idx_c = clr_idx_reg;
    end else if (bus.cfg_we) begin
      tbl_we_c     = 1'b1;
      tbl_idx_c    = bus.cfg_pc[IDX_W+1:2];
      tbl_tag_c    = bus.cfg_pc;
      tbl_target_c = bus.cfg_target;
      tbl_taken_c  = bus.cfg_taken;
      tbl_valid_c  = 1'b1;
    end else if (!fifo_empty) begin
      tbl_we_c     = 1'b1;
      tbl_idx_c    = head_pc[IDX_W+1:2];
      tbl_tag_c    = head_pc;
      tbl_target_c = head_target;
      tbl_taken_c  = head_taken;
      tbl_valid_c  = 1'b1;
    end
  end

  assign bus.tbl_we     = tbl_we_c;
  assign bus.tbl_idx    = tbl_idx_c;
  assign bus.tbl_tag    = tbl_tag_c;
  assign bus.tbl_target = tbl_target_c;
  assign bus.tbl_taken  = tbl_taken_c;
  assign bus.tbl_valid  = tbl_valid_c;
  assign bus.busy       = !in_run;
  assign bus.upd_drop   = upd_drop_reg;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl
//   Directed scenarios with literal expectations followed by randomized
//   traffic, all checked every cycle against a queue-based model of the
//   update controller. Honours BP_UPD_COALESCE_EN like the design.
module tb_bp_update_ctrl;

  localparam int DEPTH  = 4;
  localparam int IDX_W  = 8;
  localparam int ADDR_W = 32;
  localparam int NENT   = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bp_update_ctrl_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  bp_update_ctrl #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [31:0] pc);
    return (pc >> 2) & 32'(NENT - 1);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } ent_t;

  ent_t        m_q[$];
  bit          m_clear;
  int          m_clr;
  bit          m_drop;
  ent_t        m_tmp;
  bit          m_popped;
  bit          m_merged;
  logic        e_we, e_taken, e_valid, e_busy;
  logic [31:0] e_idx, e_tag, e_tgt;

  always @(negedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_clear = 1'b1;
      m_clr   = 0;
      m_drop  = 1'b0;
    end else begin
      e_we = 0; e_taken = 0; e_valid = 0; e_busy = 0;
      e_idx = 0; e_tag = 0; e_tgt = 0;
      if (m_clear) begin
        e_we = 1; e_busy = 1; e_idx = 32'(m_clr);
      end else if (bus.cfg_we) begin
        e_we = 1; e_valid = 1; e_idx = idx_of(bus.cfg_pc);
        e_tag = bus.cfg_pc; e_tgt = bus.cfg_target; e_taken = bus.cfg_taken;
      end else if (m_q.size() > 0) begin
        e_we = 1; e_valid = 1; e_idx = idx_of(m_q[0].pc);
        e_tag = m_q[0].pc; e_tgt = m_q[0].target; e_taken = m_q[0].taken;
      end
      chk("tbl_we",     32'(bus.tbl_we),    32'(e_we));
      chk("tbl_idx",    32'(bus.tbl_idx),   e_idx);
      chk("tbl_tag",    bus.tbl_tag,        e_tag);
      chk("tbl_target", bus.tbl_target,     e_tgt);
      chk("tbl_taken",  32'(bus.tbl_taken), 32'(e_taken));
      chk("tbl_valid",  32'(bus.tbl_valid), 32'(e_valid));
      chk("busy",       32'(bus.busy),      32'(e_busy));
      chk("upd_drop",   32'(bus.upd_drop),  32'(m_drop));

      // advance to the state seen after the coming rising edge
      m_drop = 1'b0;
      if (m_clear) begin
        if (bus.flush_req)      m_clr = 0;
        else if (m_clr == NENT - 1) m_clear = 1'b0;
        else                    m_clr++;
      end else begin
        m_popped = !bus.cfg_we && (m_q.size() > 0);
        if (bus.flush_req) begin
          m_q.delete();
          m_clear = 1'b1;
          m_clr   = 0;
        end else begin
          if (m_popped) void'(m_q.pop_front());
          if (bus.br_update) begin
            m_merged = 1'b0;
`ifdef BP_UPD_COALESCE_EN
            if (m_q.size() > 0 && m_q[m_q.size()-1].pc == bus.br_pc) begin
              m_tmp = m_q[m_q.size()-1];
              m_tmp.target = bus.br_address;
              m_tmp.taken  = bus.br;
              m_q[m_q.size()-1] = m_tmp;
              m_merged = 1'b1;
            end
`endif
            if (!m_merged) begin
              if (m_q.size() < DEPTH) begin
                m_tmp.pc = bus.br_pc; m_tmp.target = bus.br_address; m_tmp.taken = bus.br;
                m_q.push_back(m_tmp);
              end else begin
                m_drop = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    bus.flush_req = 0; bus.br_update = 0; bus.br = 0;
    bus.br_address = 0; bus.br_pc = 0;
    bus.cfg_we = 0; bus.cfg_pc = 0; bus.cfg_target = 0; bus.cfg_taken = 0;
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges with busy=1 from now on; the first must show index 0.
  task automatic count_sweep(input string name);
    int n;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (n == 0) chk({name, "_first_idx"}, 32'(bus.tbl_idx), 0);
      n++;
    end
    chk({name, "_len"}, 32'(n), 32'(NENT));
    $display("txn sweep %s: %0d busy cycles", name, n);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int drops;
    int n;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     32'(bus.busy),     1);
    chk("rst_we",       32'(bus.tbl_we),   1);
    chk("rst_idx",      32'(bus.tbl_idx),  0);
    chk("rst_valid",    32'(bus.tbl_valid), 0);
    chk("rst_upd_drop", 32'(bus.upd_drop), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // initial sweep: 256 busy cycles, then RUN
    count_sweep("reset_sweep");

    // single EX update, written the cycle after it is presented
    drive_cycle();
    bus.br_update = 1; bus.br_pc = 32'h104; bus.br_address = 32'h200; bus.br = 1;
    @(negedge clk);
    chk("no_bypass_we", 32'(bus.tbl_we), 0);
    drive_cycle();
    idle_inputs();
    @(negedge clk);
    chk("upd_we",     32'(bus.tbl_we),    1);
    chk("upd_idx",    32'(bus.tbl_idx),   32'h41);
    chk("upd_tag",    bus.tbl_tag,        32'h104);
    chk("upd_target", bus.tbl_target,     32'h200);
    chk("upd_taken",  32'(bus.tbl_taken), 1);
    chk("upd_valid",  32'(bus.tbl_valid), 1);
    $display("txn ex_update pc=0x104 idx=0x%0h", bus.tbl_idx);

    // cfg held 6 cycles with an update every cycle: 4 buffered, 2 dropped
    drops = 0;
    for (int k = 0; k < 6; k++) begin
      drive_cycle();
      bus.cfg_we = 1; bus.cfg_pc = 32'h1000 + 32'(16 * k);
      bus.cfg_target = 32'h9000 + 32'(k); bus.cfg_taken = 1'(k);
      bus.br_update = 1; bus.br_pc = 32'h2000 + 32'(4 * k);
      bus.br_address = 32'h3000 + 32'(4 * k); bus.br = 1'(k);
      @(negedge clk);
      drops += int'(bus.upd_drop);
      chk("cfg_tag", bus.tbl_tag, 32'h1000 + 32'(16 * k));
      $display("txn cfg_write pc=0x%0h", bus.tbl_tag);
    end
    drive_cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drops += int'(bus.upd_drop);
      chk("drain_we",  32'(bus.tbl_we), 1);
      chk("drain_tag", bus.tbl_tag, 32'h2000 + 32'(4 * k));
      $display("txn drain pc=0x%0h", bus.tbl_tag);
    end
    @(negedge clk);
    drops += int'(bus.upd_drop);
    chk("drain_done_we", 32'(bus.tbl_we), 0);
    chk("drop_pulses", 32'(drops), 2);

    // flush with 3 entries buffered
    for (int k = 0; k < 3; k++) begin
      drive_cycle();
      bus.cfg_we = 1; bus.cfg_pc = 32'h5000 + 32'(4 * k);
      bus.br_update = 1; bus.br_pc = 32'h4000 + 32'(4 * k); bus.br = 1;
    end
    drive_cycle();
    idle_inputs();
    bus.flush_req = 1;
    @(negedge clk);
    chk("flush_cycle_tag", bus.tbl_tag, 32'h4000);
    drive_cycle();
    bus.flush_req = 0;
    count_sweep("flush_sweep");
    chk("no_stale_write", 32'(bus.tbl_we), 0);

    // flush while clearing at index 100
    drive_cycle();
    bus.flush_req = 1;
    drive_cycle();
    bus.flush_req = 0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (bus.busy && bus.tbl_idx == 8'd99) break;
      n++;
    end
    chk("found_idx99", 32'(bus.tbl_idx), 99);
    drive_cycle();
    bus.flush_req = 1;
    @(negedge clk);
    chk("restart_at_idx", 32'(bus.tbl_idx), 100);
    drive_cycle();
    bus.flush_req = 0;
    count_sweep("restart_sweep");

    // two updates to the same pc while cfg blocks the port
    drive_cycle();
    bus.cfg_we = 1; bus.cfg_pc = 32'h5000;
    bus.br_update = 1; bus.br_pc = 32'h104; bus.br_address = 32'h600; bus.br = 1;
    drive_cycle();
    bus.br_address = 32'h700; bus.br = 0;
    drive_cycle();
    bus.br_update = 0;
    drive_cycle();
    idle_inputs();
    @(negedge clk);
`ifdef BP_UPD_COALESCE_EN
    chk("coal_we",     32'(bus.tbl_we),    1);
    chk("coal_taken",  32'(bus.tbl_taken), 0);
    chk("coal_target", bus.tbl_target,     32'h700);
    $display("txn coalesced write taken=%0d", bus.tbl_taken);
    @(negedge clk);
    chk("coal_single", 32'(bus.tbl_we), 0);
`else
    chk("same_pc_1_taken",  32'(bus.tbl_taken), 1);
    chk("same_pc_1_target", bus.tbl_target,     32'h600);
    $display("txn same-pc write 1 taken=%0d", bus.tbl_taken);
    @(negedge clk);
    chk("same_pc_2_we",    32'(bus.tbl_we),    1);
    chk("same_pc_2_taken", 32'(bus.tbl_taken), 0);
    $display("txn same-pc write 2 taken=%0d", bus.tbl_taken);
    @(negedge clk);
    chk("same_pc_done", 32'(bus.tbl_we), 0);
`endif

    // randomized traffic, checked cycle by cycle by the model
    for (int c = 0; c < 4000; c++) begin
      drive_cycle();
      bus.flush_req  = ($urandom_range(0, 299) == 0);
      bus.cfg_we     = !bus.flush_req && ($urandom_range(0, 99) < 40);
      bus.cfg_pc     = $urandom;
      bus.cfg_target = $urandom;
      bus.cfg_taken  = 1'($urandom_range(0, 1));
      bus.br_update  = ($urandom_range(0, 99) < 60);
      bus.br_pc      = ($urandom_range(0, 3) == 0) ? $urandom
                                                   : 32'h100 + 32'(4 * $urandom_range(0, 3));
      bus.br_address = $urandom;
      bus.br         = 1'($urandom_range(0, 1));
    end
    drive_cycle();
    idle_inputs();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Sequences all writes into the branch-predictor table: target, tag, taken and valid bits.
- Buffers EX-stage branch resolutions in a small FIFO and arbitrates the single table write port between three sources: the table-clear sweep, the config write port and buffered EX updates.
- Sits between EX and the predictor table; drives busy so IF ignores predictions while the table is being cleared.

Parameters:
DEPTH, 4, EX update FIFO entries (power of 2, >=2)
IDX_W, 8, table index width; table has 2^IDX_W entries, index = pc[IDX_W+1:2]
ADDR_W, 32, instruction address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush_req  in  1  request a full table clear (pulse)
br_update  in  1  EX resolved a branch this cycle
br  in  1  branch taken
br_address  in  ADDR_W  resolved target
br_pc  in  ADDR_W  pc of the branch
cfg_we  in  1  config write request (single-cycle, not stallable)
cfg_pc  in  ADDR_W  config tag/pc; index derived as for br_pc
cfg_target  in  ADDR_W  config target
cfg_taken  in  1  config taken bit
tbl_we  out  1  table write enable
tbl_idx  out  IDX_W  table write index
tbl_tag  out  ADDR_W  tag written
tbl_target  out  ADDR_W  target written
tbl_taken  out  1  taken bit written
tbl_valid  out  1  valid bit written
busy  out  1  clear sweep in progress
upd_drop  out  1  registered pulse: an EX update was lost to overflow

Behaviour:
- State machine: CLEAR, RUN.
  - Reset (rst low, async): state=CLEAR, clr_idx=0, FIFO empty, upd_drop=0.
- CLEAR:
  - tbl_we=1, tbl_idx=clr_idx, tbl_valid=0; tbl_tag, tbl_target and tbl_taken are 0.
  - clr_idx increments each cycle.
  - On clr_idx==2^IDX_W-1 the next state is RUN. The sweep takes exactly 2^IDX_W cycles.
  - busy=1. EX updates and cfg writes are discarded; upd_drop is not pulsed.
  - flush_req in CLEAR restarts clr_idx at 0.
- RUN:
  - busy=0.
  - flush_req: next state CLEAR, clr_idx=0, FIFO flushed. The same-cycle update and cfg write are discarded; the write port still serves its normal source this cycle.
- Write-port arbitration in RUN. The write port outputs are combinational from the current state, cfg inputs and FIFO head. Priority: cfg_we > FIFO head.
  - cfg_we=1: tbl_we=1, fields from cfg_*, tbl_valid=1, no pop.
  - Else if FIFO non-empty: tbl_we=1, fields from head, tbl_valid=1, pop.
  - Else tbl_we=0; the other outputs are don't-care, driven 0.
- FIFO:
  - Push when br_update=1 in RUN without flush_req.
  - Push-to-write latency is at least 1 cycle: there is no bypass of an empty FIFO.
  - Simultaneous push and pop with the FIFO full is allowed; count is unchanged.
  - Push with the FIFO full and no pop: the update is dropped and upd_drop=1 the next cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Index and tag: tbl_idx=pc[IDX_W+1:2]; tbl_tag is the full pc.

Optional Feature:
- Macro: BP_UPD_COALESCE_EN.
- Defined: a push whose br_pc equals the pc of the youngest FIFO entry overwrites that entry (br, br_address) instead of allocating.
  - Coalescing does not apply if that entry is being popped this cycle; the update is pushed normally.
  - A coalesced push into a full FIFO is not a drop.
- Undefined: every push allocates; there is no comparator.

Decomposition:
- Shared package/defines file: ADDR_W and IDX_W defaults (aligned with the predictor table size), the state encoding (CLEAR=0, RUN=1) and the FIFO entry layout (pc, target, taken).
- One sub-module: bp_upd_fifo, a synchronous FIFO with push, pop, full, empty, a head read port and a youngest-entry read/overwrite port for coalescing.

Test Plan:
- Release rst -> busy=1 for 256 cycles, tbl_we=1, tbl_idx sweeps 0..255, tbl_valid=0; busy=0 on cycle 257.
- RUN: br_update with br_pc=0x104, br_address=0x200, br=1 -> next cycle tbl_we=1, tbl_idx=0x41, tbl_tag=0x104, tbl_target=0x200, tbl_taken=1, tbl_valid=1.
- Hold cfg_we=1 for 6 cycles while br_update=1 each cycle -> cfg written each cycle; FIFO fills at 4; updates 5 and 6 give upd_drop pulses; all 4 buffered updates drain in order after cfg_we drops.
- flush_req with 3 entries buffered -> CLEAR restarts at idx 0, FIFO empty, no buffered update is written after the sweep.
- flush_req at clr_idx=100 -> clr_idx resets to 0; busy lasts 256 more cycles.
- BP_UPD_COALESCE_EN with cfg_we held: two updates to br_pc=0x104 (br=1 then br=0) -> one FIFO entry, written with taken=0; without the macro -> two writes, taken=1 then 0.
